// File: rtl/beta_hazard_if.sv
// Decode-side bundle for the register-hazard controller: decoded operand
// addresses, exe-stage writeback port, flush, and the issue/forward/stall
// responses returned to decode.
interface beta_hazard_if;
    logic       issue_valid_i;
    logic [4:0] issue_rs1_addr_i;
    logic [4:0] issue_rs2_addr_i;
    logic       issue_rs1_used_i;
    logic       issue_rs2_used_i;
    logic [4:0] issue_rd_addr_i;
    logic       issue_rd_wr_i;
    logic       wb_valid_i;
    logic [4:0] wb_rd_addr_i;
    logic       flush_i;
    logic       issue_ack_o;
    logic       stall_o;
    logic       forward_en_o;
    logic [1:0] forward_src_o;
    logic [5:0] pending_cnt_o;
    logic       stall_timeout_o;

    // Decode stage side: presents instructions, consumes the decisions.
    modport master (
        output issue_valid_i, issue_rs1_addr_i, issue_rs2_addr_i,
               issue_rs1_used_i, issue_rs2_used_i, issue_rd_addr_i,
               issue_rd_wr_i, wb_valid_i, wb_rd_addr_i, flush_i,
        input  issue_ack_o, stall_o, forward_en_o, forward_src_o,
               pending_cnt_o, stall_timeout_o
    );

    // Hazard controller side.
    modport slave (
        input  issue_valid_i, issue_rs1_addr_i, issue_rs2_addr_i,
               issue_rs1_used_i, issue_rs2_used_i, issue_rd_addr_i,
               issue_rd_wr_i, wb_valid_i, wb_rd_addr_i, flush_i,
        output issue_ack_o, stall_o, forward_en_o, forward_src_o,
               pending_cnt_o, stall_timeout_o
    );
endinterface

// File: rtl/beta_hazard_ctrl.sv
// Register-hazard controller for decode. A scoreboard marks registers with an
// outstanding exe-stage write; each decoded instruction either issues, issues
// with writeback forwarding, or is parked in shadow registers while the
// pipeline stalls until its blocking operands resolve.
module beta_hazard_ctrl #(
    parameter int NumRegs  = 32,
    parameter int MaxStall = 15
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    beta_hazard_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    localparam logic [7:0] MaxStallW = 8'(MaxStall);

    // x0 is hardwired; with the RV32E profile the upper 16 addresses do not exist.
    function automatic logic addr_ok(input logic [4:0] a);
        return (a != 5'd0) && ((NumRegs != 16) || !a[4]);
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

    state_e      state_r, state_next_s;
    logic [31:0] sb_r, sb_next_s, clr_mask_s, set_mask_s;
    logic [5:0]  pend_r;
    logic [7:0]  wdog_cnt_r;
    logic        tmo_r, stall_r;
    logic [4:0]  sh_rs1_r, sh_rs2_r, sh_rd_r;
    logic        sh_u1_r, sh_u2_r, sh_wr_r;

    logic        in_stall_s, ack_s, latch_s;
    logic [4:0]  cur_rs1_s, cur_rs2_s, cur_rd_s;
    logic        cur_u1_s, cur_u2_s, cur_wr_s;
    logic        dep1_s, dep2_s, fwd1_s, fwd2_s, blk1_s, blk2_s, blocked_s;

    // In STALL the parked instruction is re-evaluated; new decode input is ignored.
    assign in_stall_s = (state_r == ST_STALL);
    assign cur_rs1_s  = in_stall_s ? sh_rs1_r : bus.issue_rs1_addr_i;
    assign cur_rs2_s  = in_stall_s ? sh_rs2_r : bus.issue_rs2_addr_i;
    assign cur_u1_s   = in_stall_s ? sh_u1_r  : bus.issue_rs1_used_i;
    assign cur_u2_s   = in_stall_s ? sh_u2_r  : bus.issue_rs2_used_i;
    assign cur_rd_s   = in_stall_s ? sh_rd_r  : bus.issue_rd_addr_i;
    assign cur_wr_s   = in_stall_s ? sh_wr_r  : bus.issue_rd_wr_i;

    // A pending source is forwardable only when its producer writes back right now.
    assign dep1_s    = cur_u1_s & addr_ok(cur_rs1_s) & sb_r[cur_rs1_s];
    assign dep2_s    = cur_u2_s & addr_ok(cur_rs2_s) & sb_r[cur_rs2_s];
    assign fwd1_s    = dep1_s & bus.wb_valid_i & (bus.wb_rd_addr_i == cur_rs1_s);
    assign fwd2_s    = dep2_s & bus.wb_valid_i & (bus.wb_rd_addr_i == cur_rs2_s);
    assign blk1_s    = dep1_s & ~fwd1_s;
    assign blk2_s    = dep2_s & ~fwd2_s;
    assign blocked_s = blk1_s | blk2_s;

    // Next-state and issue decision; flush overrides everything and suppresses ack.
    always_comb begin
        state_next_s = state_r;
        ack_s        = 1'b0;
        latch_s      = 1'b0;
        if (bus.flush_i) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.issue_valid_i && blocked_s) begin
                        state_next_s = ST_STALL;
                        latch_s      = 1'b1;
                    end else begin
                        ack_s = bus.issue_valid_i;
                    end
                end
                ST_STALL: begin
                    if (!blocked_s) begin
                        ack_s        = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_STALL;
                    end
                end
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Set is applied after clear so a new producer survives a same-edge writeback.
    assign clr_mask_s = (bus.wb_valid_i && addr_ok(bus.wb_rd_addr_i))
                        ? (32'd1 << bus.wb_rd_addr_i) : 32'd0;
    assign set_mask_s = (ack_s && cur_wr_s && addr_ok(cur_rd_s))
                        ? (32'd1 << cur_rd_s) : 32'd0;
    assign sb_next_s  = (sb_r & ~clr_mask_s) | set_mask_s;

    // FSM state and the registered stall indication.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r <= ST_IDLE;
            stall_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            stall_r <= (state_next_s == ST_STALL);
        end
    end

    // Scoreboard and its lagged popcount.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sb_r   <= 32'd0;
            pend_r <= 6'd0;
        end else if (bus.flush_i) begin
            sb_r   <= 32'd0;
            pend_r <= 6'd0;
        end else begin
            sb_r   <= sb_next_s;
            pend_r <= popcount32(sb_r);
        end
    end

    // Park the blocked instruction so decode can move its inputs on.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sh_rs1_r <= 5'd0;
            sh_rs2_r <= 5'd0;
            sh_rd_r  <= 5'd0;
            sh_u1_r  <= 1'b0;
            sh_u2_r  <= 1'b0;
            sh_wr_r  <= 1'b0;
        end else if (latch_s) begin
            sh_rs1_r <= bus.issue_rs1_addr_i;
            sh_rs2_r <= bus.issue_rs2_addr_i;
            sh_rd_r  <= bus.issue_rd_addr_i;
            sh_u1_r  <= bus.issue_rs1_used_i;
            sh_u2_r  <= bus.issue_rs2_used_i;
            sh_wr_r  <= bus.issue_rd_wr_i;
        end
    end

    // Stall watchdog: counts STALL cycles, sticky flag once MaxStall is reached.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wdog_cnt_r <= 8'd0;
            tmo_r      <= 1'b0;
        end else if (bus.flush_i) begin
            wdog_cnt_r <= 8'd0;
            tmo_r      <= 1'b0;
        end else if (in_stall_s) begin
            if (ack_s) begin
                wdog_cnt_r <= 8'd0;
            end else if (wdog_cnt_r != MaxStallW) begin
                wdog_cnt_r <= wdog_cnt_r + 8'd1;
            end
            if (({1'b0, wdog_cnt_r} + 9'd1) >= {1'b0, MaxStallW}) begin
                tmo_r <= 1'b1;
            end
        end else begin
            wdog_cnt_r <= 8'd0;
        end
    end

    assign bus.issue_ack_o     = ack_s;
    assign bus.forward_en_o    = ack_s & (fwd1_s | fwd2_s);
    assign bus.forward_src_o   = ack_s ? {fwd2_s, fwd1_s} : 2'b00;
    assign bus.stall_o         = stall_r;
    assign bus.pending_cnt_o   = pend_r;
    assign bus.stall_timeout_o = tmo_r;

endmodule

// File: tb/tb_beta_hazard_ctrl.sv
// Bench for beta_hazard_ctrl: a full-profile and an RV32E instance share the
// same stimulus; a behavioural model predicts each cycle's outputs into
// per-instance queues that a negedge monitor drains and compares.
module tb_beta_hazard_ctrl;

    localparam int MaxStallTb = 4;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
    } ins_t;

    typedef struct packed {
        logic       ack;
        logic       stall;
        logic       fen;
        logic [1:0] fsrc;
        logic [5:0] pc;
        logic       to;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;

    // Free-running clock.
    always #5 clk = ~clk;

    beta_hazard_if if_a ();
    beta_hazard_if if_e ();

    beta_hazard_ctrl #(.NumRegs(32), .MaxStall(MaxStallTb)) dut_a (
        .clk_i(clk), .rstn_i(rstn), .bus(if_a.slave));
    beta_hazard_ctrl #(.NumRegs(16), .MaxStall(MaxStallTb)) dut_e (
        .clk_i(clk), .rstn_i(rstn), .bus(if_e.slave));

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q_a[$];
    exp_t q_e[$];

    // Reference model state, index 0 = 32-register instance, 1 = RV32E.
    logic [31:0] pend_m [2];
    logic        stalled_m [2];
    ins_t        held_m [2];
    int          scyc_m [2];
    logic        to_m [2];
    int          lag_m [2];

    function automatic ins_t mk(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                                logic u2, logic [4:0] rd, logic wr);
        ins_t t;
        t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd; t.wr = wr;
        return t;
    endfunction

    function automatic logic reg_ok(logic [4:0] a, int nr);
        return (a != 5'd0) && (int'(a) < nr);
    endfunction

    function automatic logic [4:0] pick();
        if ($urandom_range(0, 9) < 7) return 5'($urandom_range(0, 7));
        else return 5'($urandom_range(0, 31));
    endfunction

    task automatic check(string who, string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0d expected %0d at %0t", who, name, act, exp, $time);
        end
    endtask

    // Behavioural model: outputs for this cycle, then state as of the next edge.
    task automatic model_step(input int k, input ins_t ins, input logic wbv,
                              input logic [4:0] wba, input logic fl, output exp_t e);
        int   nr, c;
        ins_t cur;
        logic present, d1, d2, f1, f2, b1, b2, ack;
        nr      = (k == 0) ? 32 : 16;
        cur     = stalled_m[k] ? held_m[k] : ins;
        present = stalled_m[k] | ins.v;
        d1  = cur.u1 && reg_ok(cur.rs1, nr) && pend_m[k][cur.rs1];
        d2  = cur.u2 && reg_ok(cur.rs2, nr) && pend_m[k][cur.rs2];
        f1  = d1 && wbv && (wba == cur.rs1);
        f2  = d2 && wbv && (wba == cur.rs2);
        b1  = d1 && !f1;
        b2  = d2 && !f2;
        ack = present && !b1 && !b2 && !fl;
        e.ack   = ack;
        e.stall = stalled_m[k];
        e.fen   = ack && (f1 || f2);
        e.fsrc  = ack ? {f2, f1} : 2'b00;
        e.pc    = 6'(lag_m[k]);
        e.to    = to_m[k];
        if (fl) begin
            pend_m[k] = 32'd0; stalled_m[k] = 1'b0; scyc_m[k] = 0;
            to_m[k] = 1'b0; lag_m[k] = 0;
        end else begin
            c = 0;
            for (int i = 0; i < 32; i++) c += int'(pend_m[k][i]);
            lag_m[k] = c;
            if (wbv && reg_ok(wba, nr)) pend_m[k][wba] = 1'b0;
            if (ack && cur.wr && reg_ok(cur.rd, nr)) pend_m[k][cur.rd] = 1'b1;
            if (stalled_m[k]) begin
                scyc_m[k]++;
                if (scyc_m[k] >= MaxStallTb) to_m[k] = 1'b1;
                if (ack) begin
                    stalled_m[k] = 1'b0;
                    scyc_m[k] = 0;
                end
            end else if (present && (b1 || b2)) begin
                stalled_m[k] = 1'b1;
                held_m[k] = cur;
            end
        end
    endtask

    // Drive both instances for the current cycle and queue the predictions.
    task automatic step_now(input ins_t ins, input logic wbv, input logic [4:0] wba,
                            input logic fl);
        exp_t ea, ee;
        if_a.issue_valid_i = ins.v;   if_e.issue_valid_i = ins.v;
        if_a.issue_rs1_addr_i = ins.rs1; if_e.issue_rs1_addr_i = ins.rs1;
        if_a.issue_rs2_addr_i = ins.rs2; if_e.issue_rs2_addr_i = ins.rs2;
        if_a.issue_rs1_used_i = ins.u1;  if_e.issue_rs1_used_i = ins.u1;
        if_a.issue_rs2_used_i = ins.u2;  if_e.issue_rs2_used_i = ins.u2;
        if_a.issue_rd_addr_i = ins.rd;   if_e.issue_rd_addr_i = ins.rd;
        if_a.issue_rd_wr_i = ins.wr;     if_e.issue_rd_wr_i = ins.wr;
        if_a.wb_valid_i = wbv;           if_e.wb_valid_i = wbv;
        if_a.wb_rd_addr_i = wba;         if_e.wb_rd_addr_i = wba;
        if_a.flush_i = fl;               if_e.flush_i = fl;
        model_step(0, ins, wbv, wba, fl, ea);
        q_a.push_back(ea);
        model_step(1, ins, wbv, wba, fl, ee);
        q_e.push_back(ee);
    endtask

    task automatic cyc(input ins_t ins, input logic wbv, input logic [4:0] wba,
                       input logic fl);
        @(posedge clk);
        #1;
        step_now(ins, wbv, wba, fl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), 1'b0, 5'd0, 1'b0);
    endtask

    // Monitor: compare each instance's outputs against the queued prediction.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("dut_a", "ack",     int'(if_a.issue_ack_o),     int'(e.ack));
            check("dut_a", "stall",   int'(if_a.stall_o),         int'(e.stall));
            check("dut_a", "fwd_en",  int'(if_a.forward_en_o),    int'(e.fen));
            check("dut_a", "fwd_src", int'(if_a.forward_src_o),   int'(e.fsrc));
            check("dut_a", "pending", int'(if_a.pending_cnt_o),   int'(e.pc));
            check("dut_a", "timeout", int'(if_a.stall_timeout_o), int'(e.to));
        end
        if (q_e.size() > 0) begin
            e = q_e.pop_front();
            check("dut_e", "ack",     int'(if_e.issue_ack_o),     int'(e.ack));
            check("dut_e", "stall",   int'(if_e.stall_o),         int'(e.stall));
            check("dut_e", "fwd_en",  int'(if_e.forward_en_o),    int'(e.fen));
            check("dut_e", "fwd_src", int'(if_e.forward_src_o),   int'(e.fsrc));
            check("dut_e", "pending", int'(if_e.pending_cnt_o),   int'(e.pc));
            check("dut_e", "timeout", int'(if_e.stall_timeout_o), int'(e.to));
        end
    end

    // Stimulus: reset, directed scenarios, randomized traffic, drain, summary.
    initial begin : stim
        ins_t r;
        int   w;
        for (int k = 0; k < 2; k++) begin
            pend_m[k] = 32'd0; stalled_m[k] = 1'b0; held_m[k] = '0;
            scyc_m[k] = 0; to_m[k] = 1'b0; lag_m[k] = 0;
        end
        rstn = 1'b0;
        if_a.issue_valid_i = 1'b0; if_e.issue_valid_i = 1'b0;
        if_a.wb_valid_i = 1'b0;    if_e.wb_valid_i = 1'b0;
        if_a.flush_i = 1'b0;       if_e.flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        step_now(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), 1'b0, 5'd0, 1'b0);

        // Independent stream.
        cyc(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1), 1'b0, 5'd0, 1'b0);
        cyc(mk(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0), 1'b0, 5'd0, 1'b0);
        idle(2);
        // RAW stall on x5 resolved by a writeback forward.
        cyc(mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0), 1'b0, 5'd0, 1'b0);
        idle(2);
        cyc(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), 1'b1, 5'd5, 1'b0);
        idle(2);
        // Same-cycle forward on rs2.
        cyc(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1), 1'b0, 5'd0, 1'b0);
        idle(1);
        cyc(mk(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0), 1'b1, 5'd7, 1'b0);
        idle(2);
        // Set/clear collision, then a write to x0.
        cyc(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1), 1'b0, 5'd0, 1'b0);
        cyc(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1), 1'b1, 5'd3, 1'b0);
        idle(2);
        cyc(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1), 1'b1, 5'd0, 1'b0);
        idle(2);
        // Watchdog on a never-resolved x9, then flush.
        cyc(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1), 1'b0, 5'd0, 1'b0);
        cyc(mk(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0), 1'b0, 5'd0, 1'b0);
        idle(7);
        cyc(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), 1'b0, 5'd0, 1'b1);
        idle(2);
        // Upper register under both profiles.
        cyc(mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1), 1'b0, 5'd0, 1'b0);
        cyc(mk(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0), 1'b0, 5'd0, 1'b0);
        idle(2);
        cyc(mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), 1'b0, 5'd0, 1'b1);
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = mk($urandom_range(0, 3) != 0, pick(), 1'($urandom_range(0, 1)),
                   pick(), 1'($urandom_range(0, 1)), pick(), 1'($urandom_range(0, 1)));
            cyc(r, $urandom_range(0, 2) == 0, pick(), $urandom_range(0, 63) == 0);
        end
        idle(2);

        w = 0;
        while (w < 10 && (q_a.size() > 0 || q_e.size() > 0)) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("tb", "drain", q_a.size() + q_e.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
